// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: glyph table, blank pattern, FSM states.
package sseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Segment patterns indexed by hex value, bits written g..a (bit0 = a).
  localparam logic [6:0] SSEG_GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SSEG_BLANK = 7'h00;

  // True when the pattern matches one of the sixteen hex glyphs.
  function automatic logic glyph_legal(input logic [6:0] seg);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (SSEG_GLYPHS[i] == seg) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/sseg_glyph2num.sv
// Combinational reverse lookup: segment pattern (1 = on) to hex nibble.
module sseg_glyph2num
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  // Match against the shared glyph table; nibble is 0 when nothing matches.
  always_comb begin
    legal  = glyph_legal(seg);
    blank  = (seg == SSEG_BLANK);
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (SSEG_GLYPHS[i] == seg) nibble = 4'(i);
    end
  end

endmodule

// File: rtl/sseg_capture.sv
// Samples a multiplexed seven-segment bus, filters scan ghosting and
// stores the hex value shown on each digit position.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit INV    = 1'b1,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [6:0]            sseg,
  input  logic [DIGITS-1:0]     dsel,
  output logic [4*DIGITS-1:0]   num,
  output logic [DIGITS-1:0]     num_vld,
  output logic [DIGITS-1:0]     blank,
  output logic                  frame,
  output logic                  err
);

  localparam int CW = $clog2(STABLE + 1);

  // Two-stage synchronizer, then the previous normalized sample.
  logic [6:0]          seg_s1_q, seg_s2_q, seg_p_q;
  logic [DIGITS-1:0]   dsel_s1_q, dsel_s2_q, dsel_p_q;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   dsel_n;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                capture;

  logic [4*DIGITS-1:0] num_q, num_d;
  logic [DIGITS-1:0]   vld_q, vld_d, blank_q, blank_d;
  logic [DIGITS-1:0]   seen_q, seen_d, seen_set;
  logic                frame_q, frame_d, err_q, err_d;

  logic                changed, sel_one, sel_multi, prev_multi;
  logic                g_legal, g_blank;
  logic [3:0]          g_nibble;

  // Inside the block 1 always means "on".
  assign seg_n  = seg_s2_q ^ {7{INV}};
  assign dsel_n = dsel_s2_q ^ {DIGITS{INV}};

  assign changed    = ({seg_n, dsel_n} != {seg_p_q, dsel_p_q});
  assign sel_one    = $onehot(dsel_n);
  assign sel_multi  = (dsel_n != '0) && !sel_one;
  assign prev_multi = (dsel_p_q != '0) && !$onehot(dsel_p_q);

  // The tracked sample equals the current one whenever a capture fires.
  sseg_glyph2num u_glyph (
    .seg    (seg_p_q),
    .legal  (g_legal),
    .blank  (g_blank),
    .nibble (g_nibble)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state and dwell counter; a change always restarts the dwell.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE || changed) begin
      if (sel_one) begin
        state_d = ST_TRACK;
        cnt_d   = CW'(1);
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else if (state_q == ST_TRACK) begin
      if (cnt_q == CW'(STABLE)) state_d = ST_DONE;
      else                      cnt_d   = cnt_q + CW'(1);
    end
  end

  // FSM output: capture once the pattern has survived the full dwell.
  always_comb begin
    capture = (state_q == ST_TRACK) && !changed && (cnt_q == CW'(STABLE));
  end

  // Capture registers, seen mask and strobe sources.
  always_comb begin
    num_d    = num_q;
    vld_d    = vld_q;
    blank_d  = blank_q;
    seen_set = seen_q | (capture ? dsel_p_q : '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (capture && dsel_p_q[i]) begin
        if (g_legal) num_d[4*i +: 4] = g_nibble;
        vld_d[i]   = g_legal;
        blank_d[i] = g_blank;
      end
    end
    frame_d = capture && (&seen_set);
    seen_d  = frame_d ? '0 : seen_set;
    err_d   = (capture && !g_legal && !g_blank) || (sel_multi && !prev_multi);
  end

  // Synchronizer and datapath registers; everything holds while clk_en=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q  <= {7{INV}};
      seg_s2_q  <= {7{INV}};
      dsel_s1_q <= {DIGITS{INV}};
      dsel_s2_q <= {DIGITS{INV}};
      seg_p_q   <= '0;
      dsel_p_q  <= '0;
      num_q     <= '0;
      vld_q     <= '0;
      blank_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
    end else if (clk_en) begin
      seg_s1_q  <= sseg;
      seg_s2_q  <= seg_s1_q;
      dsel_s1_q <= dsel;
      dsel_s2_q <= dsel_s1_q;
      seg_p_q   <= seg_n;
      dsel_p_q  <= dsel_n;
      num_q     <= num_d;
      vld_q     <= vld_d;
      blank_q   <= blank_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  // A pending strobe shows only in an enabled cycle and clears on that edge.
  assign frame   = frame_q & clk_en;
  assign err     = err_q & clk_en;
  assign num     = num_q;
  assign num_vld = vld_q;
  assign blank   = blank_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture (DIGITS=4, INV=1, STABLE=4).
module tb_sseg_capture;

  localparam logic [6:0] G1 = 7'h06;
  localparam logic [6:0] G3 = 7'h4F;
  localparam logic [6:0] G5 = 7'h6D;
  localparam logic [6:0] G8 = 7'h7F;
  localparam logic [6:0] GA = 7'h77;
  localparam logic [6:0] GF = 7'h71;
  localparam logic [6:0] GBAD = 7'h49;
  localparam logic [6:0] GOFF = 7'h00;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic [6:0]  sseg;
  logic [3:0]  dsel;
  logic [15:0] num;
  logic [3:0]  num_vld, blank;
  logic        frame, err;

  int  checks = 0;
  int  failures = 0;
  int  frame_cnt = 0;
  int  err_cnt = 0;
  int  f0, e0;
  bit  toggle_en = 1'b0;

  sseg_capture #(.DIGITS(4), .INV(1'b1), .STABLE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .sseg    (sseg),
    .dsel    (dsel),
    .num     (num),
    .num_vld (num_vld),
    .blank   (blank),
    .frame   (frame),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame) frame_cnt++;
    if (err)   err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // n enabled cycles; in toggle mode each is preceded by a disabled cycle.
  task automatic en_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (toggle_en) begin
        clk_en = 1'b0;
        @(posedge clk); #1;
      end
      clk_en = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Drive one glyph on one digit, active-low.
  task automatic show(input logic [6:0] glyph, input int digit, input int n);
    sseg = ~glyph;
    dsel = ~(4'b0001 << digit);
    en_cycles(n);
  endtask

  task automatic idle(input int n);
    sseg = 7'h7F;
    dsel = 4'hF;
    en_cycles(n);
  endtask

  task automatic scan_1a3f;
    show(GF, 0, 10);
    show(G3, 1, 10);
    show(GA, 2, 10);
    show(G1, 3, 10);
    idle(4);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; sseg = 7'h7F; dsel = 4'hF;
    @(posedge clk); @(posedge clk); #1;
    check_eq("reset_num", num, 16'h0);
    check_eq("reset_vld", num_vld, 4'h0);
    check_eq("reset_blank", blank, 4'h0);
    check_eq("reset_strobes", {frame, err}, 2'b00);
    rst = 1'b0;

    // Clean scan of "1A3F".
    f0 = frame_cnt; e0 = err_cnt;
    scan_1a3f();
    check_eq("scan_num", num, 16'h1A3F);
    check_eq("scan_vld", num_vld, 4'hF);
    check_eq("scan_blank", blank, 4'h0);
    check_eq("scan_frames", frame_cnt - f0, 1);
    check_eq("scan_errs", err_cnt - e0, 0);

    // Illegal glyph on digit 2.
    f0 = frame_cnt; e0 = err_cnt;
    show(GF, 0, 10);
    show(G3, 1, 10);
    show(GBAD, 2, 8);
    show(G1, 3, 10);
    idle(4);
    check_eq("bad_num", num, 16'h1A3F);
    check_eq("bad_vld", num_vld, 4'b1011);
    check_eq("bad_blank", blank, 4'h0);
    check_eq("bad_frames", frame_cnt - f0, 1);
    check_eq("bad_errs", err_cnt - e0, 1);

    // Dwell too short: 3 samples against STABLE=4.
    f0 = frame_cnt; e0 = err_cnt;
    show(G8, 0, 3);
    show(G8, 1, 3);
    show(G8, 2, 3);
    show(G8, 3, 3);
    idle(4);
    check_eq("short_num", num, 16'h1A3F);
    check_eq("short_vld", num_vld, 4'b1011);
    check_eq("short_frames", frame_cnt - f0, 0);
    check_eq("short_errs", err_cnt - e0, 0);

    // Two digits selected (raw 0011 is active-low, so digits 2 and 3).
    f0 = frame_cnt; e0 = err_cnt;
    sseg = ~G8; dsel = 4'b0011;
    en_cycles(6);
    check_eq("multi_errs", err_cnt - e0, 1);
    check_eq("multi_num", num, 16'h1A3F);
    check_eq("multi_frames", frame_cnt - f0, 0);
    // Clean "8" on digit 0: inputs present from cycle 0, capture on the
    // edge ending cycle STABLE+2 = 6, i.e. the 7th edge.
    sseg = ~G8; dsel = 4'b1110;
    en_cycles(6);
    check_eq("lat_before", num[3:0], 4'hF);
    en_cycles(1);
    check_eq("lat_after", num[3:0], 4'h8);
    check_eq("lat_vld", num_vld, 4'b1011);
    idle(4);

    // Reset, then the same scan with clk_en toggling.
    rst = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    toggle_en = 1'b1;
    f0 = frame_cnt; e0 = err_cnt;
    scan_1a3f();
    check_eq("tog_num", num, 16'h1A3F);
    check_eq("tog_vld", num_vld, 4'hF);
    check_eq("tog_frames", frame_cnt - f0, 1);
    check_eq("tog_errs", err_cnt - e0, 0);

    // Reset in the middle of TRACK, with clk_en low in the reset cycle.
    show(G5, 0, 4);
    rst = 1'b1; clk_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_num", num, 16'h0);
    check_eq("rst_flags", {num_vld, blank}, 8'h00);
    check_eq("rst_strobes", {frame, err}, 2'b00);
    en_cycles(6);
    check_eq("recap_before", num, 16'h0);
    en_cycles(1);
    check_eq("recap_after", num, 16'h0005);
    check_eq("recap_vld", num_vld, 4'b0001);

    // Blank glyph on digit 1: keeps num, clears valid, sets blank.
    toggle_en = 1'b0;
    e0 = err_cnt;
    show(GOFF, 1, 10);
    idle(4);
    check_eq("blank_num", num, 16'h0005);
    check_eq("blank_vld", num_vld, 4'b0001);
    check_eq("blank_bits", blank, 4'b0010);
    check_eq("blank_errs", err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
